// File: rtl/irrigation_scheduler.sv
// Round-robin pump scheduler: grants one zone at a time and sequences it
// through valve-settle, pump-run and cooldown. All outputs are registered.
module irrigation_scheduler #(
    parameter int ZONES       = 4,
    parameter int DUR_W       = 12,
    parameter int DEFAULT_DUR = 1000,
    parameter int SETTLE      = 16,
    parameter int COOLDOWN    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [ZONES-1:0] req,
    input  logic             abort,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_zone,
    input  logic [DUR_W-1:0] cfg_dur,
    output logic             pump_on,
    output logic [ZONES-1:0] valve_en,
    output logic [1:0]       active_zone,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RUN,
        ST_COOL
    } state_t;

    localparam logic [DUR_W-1:0] SETTLE_LD = DUR_W'(SETTLE - 1);
    localparam logic [DUR_W-1:0] COOL_LD   = DUR_W'(COOLDOWN - 1);
    localparam logic [DUR_W-1:0] DUR_RST   = DUR_W'(DEFAULT_DUR);
    localparam logic [1:0]       LAST_RST  = 2'(ZONES - 1);

    state_t             state_q, state_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic [DUR_W-1:0]   run_dur_q, run_dur_d;
    logic [DUR_W-1:0]   dur_q [ZONES];
    logic [DUR_W-1:0]   dur_d [ZONES];
    logic [ZONES-1:0]   pending_q, pending_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [1:0]         active_zone_q, active_zone_d;
    logic [ZONES-1:0]   valve_en_q, valve_en_d;
    logic               pump_on_q, pump_on_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [ZONES-1:0]   nz;
    logic [ZONES-1:0]   req_eff;
    logic [3:0]         elig;
    logic [2:0]         pick;

    // {found, zone}: first eligible zone after 'last', wrapping at ZONES
    function automatic logic [2:0] rr_pick(input logic [3:0] el, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        idx = last;
        for (int k = 0; k < ZONES; k++) begin
            idx = (idx == LAST_RST) ? 2'd0 : idx + 2'd1;
            if (!res[2] && el[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [ZONES-1:0] zone_oh(input logic [1:0] z);
        logic [3:0] w;
        w = 4'b0001 << z;
        return w[ZONES-1:0];
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        run_dur_d     = run_dur_q;
        dur_d         = dur_q;
        pending_d     = pending_q;
        last_grant_d  = last_grant_q;
        active_zone_d = active_zone_q;
        valve_en_d    = valve_en_q;
        pump_on_d     = pump_on_q;
        busy_d        = busy_q;
        done_d        = done_q;

        nz = '0;
        for (int i = 0; i < ZONES; i++) nz[i] = (dur_q[i] != '0);

        // The granted zone's own request is ignored while it is being served
        req_eff = req;
        if (state_q == ST_SETTLE || state_q == ST_RUN)
            req_eff = req & ~zone_oh(active_zone_q);

        elig = 4'((pending_q | req) & nz);
        pick = rr_pick(elig, last_grant_q);

        if (ena) begin
            done_d    = 1'b0;
            pending_d = (pending_q | req_eff) & nz;

            if (cfg_we) begin
                for (int i = 0; i < ZONES; i++)
                    if (cfg_zone == 2'(i)) dur_d[i] = cfg_dur;
            end

            if (abort) begin
                pending_d = '0;
                if (state_q == ST_SETTLE || state_q == ST_RUN) begin
                    state_d = ST_COOL;
                    cnt_d   = COOL_LD;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pick[2]) begin
                            state_d       = ST_SETTLE;
                            cnt_d         = SETTLE_LD;
                            active_zone_d = pick[1:0];
                            last_grant_d  = pick[1:0];
                            pending_d     = pending_d & ~zone_oh(pick[1:0]);
                            for (int i = 0; i < ZONES; i++)
                                if (pick[1:0] == 2'(i)) run_dur_d = dur_q[i];
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_q == '0) begin
                            state_d = ST_RUN;
                            cnt_d   = run_dur_q - DUR_W'(1);
                        end else begin
                            cnt_d = cnt_q - DUR_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (cnt_q == '0) begin
                            state_d = ST_COOL;
                            cnt_d   = COOL_LD;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - DUR_W'(1);
                        end
                    end
                    ST_COOL: begin
                        if (cnt_q == '0) state_d = ST_IDLE;
                        else             cnt_d   = cnt_q - DUR_W'(1);
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            // Actuator outputs are decoded from the next state so they register with it
            pump_on_d  = (state_d == ST_RUN);
            valve_en_d = (state_d == ST_SETTLE || state_d == ST_RUN) ? zone_oh(active_zone_d) : '0;
            busy_d     = (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            run_dur_q     <= '0;
            pending_q     <= '0;
            last_grant_q  <= LAST_RST;
            active_zone_q <= '0;
            valve_en_q    <= '0;
            pump_on_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            for (int i = 0; i < ZONES; i++) dur_q[i] <= DUR_RST;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            run_dur_q     <= run_dur_d;
            pending_q     <= pending_d;
            last_grant_q  <= last_grant_d;
            active_zone_q <= active_zone_d;
            valve_en_q    <= valve_en_d;
            pump_on_q     <= pump_on_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            dur_q         <= dur_d;
        end
    end

    assign pump_on     = pump_on_q;
    assign valve_en    = valve_en_q;
    assign active_zone = active_zone_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: expected grants are queued when
// requests are driven and checked by a monitor as each valve opens and closes.
module tb_irrigation_scheduler;

    localparam int ZONES    = 4;
    localparam int DUR_W    = 12;
    localparam int SETTLE   = 4;
    localparam int COOLDOWN = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic [3:0]       req = '0;
    logic             abort = 1'b0;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_zone = '0;
    logic [DUR_W-1:0] cfg_dur = '0;
    logic             pump_on;
    logic [3:0]       valve_en;
    logic [1:0]       active_zone;
    logic             busy;
    logic             done;

    irrigation_scheduler #(
        .ZONES(ZONES), .DUR_W(DUR_W), .DEFAULT_DUR(1000),
        .SETTLE(SETTLE), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .abort(abort),
        .cfg_we(cfg_we), .cfg_zone(cfg_zone), .cfg_dur(cfg_dur),
        .pump_on(pump_on), .valve_en(valve_en), .active_zone(active_zone),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int zone;
        int settle;
        int run;
        int done;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   nchecks = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   grants_seen = 0;
    int   last_rise = 0;
    int   settle_n = 0;
    int   run_n = 0;
    int   g0 = 0;
    bit   mon_en = 1'b0;
    bit   in_grant = 1'b0;
    bit   v_prev = 1'b0;
    bit   p_prev = 1'b0;

    task automatic chk(input string tag, input int got, input int expv);
        nchecks++;
        if (got !== expv) begin
            nfail++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expectation per valve opening, measures settle/run lengths
    always @(negedge clk) begin
        if (!mon_en) begin
            in_grant = 1'b0;
            v_prev   = 1'b0;
            p_prev   = 1'b0;
        end else begin
            if (valve_en != 4'b0) chk("valve_onehot", int'($onehot(valve_en)), 1);
            if (pump_on) chk("pump_needs_valve", int'(valve_en != 4'b0), 1);
            if (valve_en != 4'b0 && !v_prev) begin
                grants_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", int'(valve_en), 0);
                end else begin
                    cur      = exp_q.pop_front();
                    in_grant = 1'b1;
                    settle_n = 0;
                    run_n    = 0;
                    chk("grant_zone", int'(active_zone), cur.zone);
                    chk("grant_valve", int'(valve_en), 1 << cur.zone);
                    if (cur.gap >= 0) chk("grant_gap", cyc - last_rise, cur.gap);
                end
                last_rise = cyc;
            end
            if (in_grant) begin
                if (pump_on && !p_prev) chk("settle_len", settle_n, cur.settle);
                if (valve_en != 4'b0 && !pump_on) settle_n++;
                if (pump_on) run_n++;
                if (valve_en == 4'b0 && v_prev) begin
                    chk("pump_at_close", int'(pump_on), 0);
                    chk("run_len", run_n, cur.run);
                    chk("done_at_close", int'(done), cur.done);
                    in_grant = 1'b0;
                end
            end
            v_prev = (valve_en != 4'b0);
            p_prev = pump_on;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int z, input int s, input int r, input int d, input int g);
        exp_t e;
        e.zone = z; e.settle = s; e.run = r; e.done = d; e.gap = g;
        exp_q.push_back(e);
    endtask

    task automatic cfg(input int z, input int d);
        cfg_we   = 1'b1;
        cfg_zone = 2'(z);
        cfg_dur  = DUR_W'(d);
        tick(1);
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_req(input logic [3:0] r);
        req = r;
        tick(1);
        req = '0;
    endtask

    // sel 0: pump_on, 1: done, other: grants_seen >= target
    task automatic wait_ev(input int sel, input int target, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = pump_on;
                1:       hit = done;
                default: hit = (grants_seen >= target);
            endcase
        end
        if (!hit) chk(tag, 0, 1);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        exp_q.delete();
        ena = 1'b1; req = '0; abort = 1'b0; cfg_we = 1'b0;
        rst_n = 1'b0;
        tick(2);
        chk("rst_pump", int'(pump_on), 0);
        chk("rst_valve", int'(valve_en), 0);
        chk("rst_active", int'(active_zone), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        tick(1);
        mon_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // Reset values and a single zone-2 run
        do_reset();
        cfg(2, 10);
        push_exp(2, SETTLE, 10, 1, -1);
        pulse_req(4'b0100);
        chk("z2_valve_t1", int'(valve_en), 4'b0100);
        chk("z2_pump_t1", int'(pump_on), 0);
        tick(3);  chk("z2_pump_t4", int'(pump_on), 0);
        tick(1);  chk("z2_pump_t5", int'(pump_on), 1);
        tick(9);  chk("z2_pump_t14", int'(pump_on), 1);
                  chk("z2_done_t14", int'(done), 0);
        tick(1);  chk("z2_pump_t15", int'(pump_on), 0);
                  chk("z2_done_t15", int'(done), 1);
                  chk("z2_valve_t15", int'(valve_en), 0);
        tick(1);  chk("z2_done_t16", int'(done), 0);
        tick(6);  chk("z2_busy_t22", int'(busy), 1);
        tick(1);  chk("z2_busy_t23", int'(busy), 0);

        // Round-robin with all requests held
        do_reset();
        for (int z = 0; z < ZONES; z++) cfg(z, 3);
        g0 = grants_seen;
        push_exp(0, SETTLE, 3, 1, -1);
        push_exp(1, SETTLE, 3, 1, SETTLE + 3 + COOLDOWN + 1);
        push_exp(2, SETTLE, 3, 1, SETTLE + 3 + COOLDOWN + 1);
        push_exp(3, SETTLE, 3, 1, SETTLE + 3 + COOLDOWN + 1);
        push_exp(0, SETTLE, 3, 1, SETTLE + 3 + COOLDOWN + 1);
        req = 4'b1111;
        wait_ev(2, g0 + 5, 120, "rr_grant_timeout");
        @(posedge clk); #1;
        req = '0;
        wait_ev(1, 0, 30, "rr_done_timeout");
        @(posedge clk); #1;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("rr_busy_abort_cool", int'(busy), 1);
        tick(40);
        chk("rr_busy_end", int'(busy), 0);
        chk("rr_grant_count", grants_seen - g0, 5);
        chk("rr_sb_empty", exp_q.size(), 0);

        // Abort during zone 1 RUN with zone 3 pending
        do_reset();
        cfg(1, 20);
        g0 = grants_seen;
        push_exp(1, SETTLE, 3, 0, -1);
        pulse_req(4'b0010);
        pulse_req(4'b1000);
        wait_ev(0, 0, 20, "abort_pump_timeout");
        @(posedge clk);
        @(posedge clk); #1;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_pump", int'(pump_on), 0);
        chk("abort_valve", int'(valve_en), 0);
        chk("abort_done", int'(done), 0);
        tick(7);  chk("abort_busy_cool", int'(busy), 1);
        tick(1);  chk("abort_busy_idle", int'(busy), 0);
        tick(30);
        chk("abort_no_regrant", grants_seen - g0, 1);
        chk("abort_sb_empty", exp_q.size(), 0);

        // Zone with zero duration is never granted
        do_reset();
        cfg(0, 3);
        cfg(1, 0);
        g0 = grants_seen;
        req = 4'b0010;
        tick(30);
        chk("dis_valve", int'(valve_en), 0);
        chk("dis_busy", int'(busy), 0);
        req = '0;
        push_exp(0, SETTLE, 3, 1, -1);
        pulse_req(4'b0011);
        wait_ev(1, 0, 40, "dis_done_timeout");
        tick(30);
        chk("dis_grant_count", grants_seen - g0, 1);
        chk("dis_sb_empty", exp_q.size(), 0);

        // Duration write during a run applies from the next grant
        do_reset();
        cfg(0, 20);
        push_exp(0, SETTLE, 20, 1, -1);
        pulse_req(4'b0001);
        wait_ev(0, 0, 20, "cfg_pump_timeout");
        cfg(0, 5);
        wait_ev(1, 0, 40, "cfg_done1_timeout");
        push_exp(0, SETTLE, 5, 1, -1);
        pulse_req(4'b0001);
        wait_ev(1, 0, 60, "cfg_done2_timeout");
        chk("cfg_sb_empty", exp_q.size(), 0);

        // Clock-enable freeze in SETTLE, then async reset mid-RUN
        do_reset();
        cfg(0, 20);
        push_exp(0, SETTLE + 7, 20, 1, -1);
        pulse_req(4'b0001);
        tick(1);
        ena = 1'b0;
        tick(7);
        chk("frz_valve_held", int'(valve_en), 4'b0001);
        chk("frz_pump_held", int'(pump_on), 0);
        ena = 1'b1;
        tick(2);  chk("frz_pump_late", int'(pump_on), 0);
        tick(1);  chk("frz_pump_rise", int'(pump_on), 1);
        tick(3);
        chk("frz_sb_empty", exp_q.size(), 0);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pump", int'(pump_on), 0);
        chk("arst_valve", int'(valve_en), 0);
        chk("arst_busy", int'(busy), 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
